// File: rtl/pixel_quad_gen.sv
// Raster-stream 4-neighbour quad generator: two line buffers plus a left-pixel
// register turn a pixel stream into {top, bottom, left, right} quads for interior centres.
module pixel_quad_gen #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   in_pixel,
    input  logic               in_sof,
    output logic               quad_valid,
    output logic [4*PIX_W-1:0] quad,
    output logic               quad_last,
    output logic               frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_PEN  = CW'(IMG_W - 2);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_lb0 [IMG_W];  // row r-2
    logic [PIX_W-1:0] r_lb1 [IMG_W];  // row r-1, overwritten in place by row r
    logic [PIX_W-1:0] r_left;

    logic [CW-1:0] w_col, w_col_n, w_cp1;
    logic [RW-1:0] w_row, w_row_n;
    logic          w_sof, w_emit, w_last, w_done;

    // A qualified in_sof relabels the current pixel as (0,0) of a fresh frame.
    assign w_sof = in_valid && in_sof;
    assign w_col = w_sof ? '0 : r_col;
    assign w_row = w_sof ? '0 : r_row;
    assign w_cp1 = (w_col == C_LAST) ? w_col : w_col + CW'(1);

    assign w_emit = in_valid && (w_row >= R_TWO) && (w_col != '0) && (w_col != C_LAST);
    assign w_last = (w_row == R_LAST) && (w_col == C_PEN);
    assign w_done = in_valid && (w_row == R_LAST) && (w_col == C_LAST);

    always_comb begin
        w_col_n = w_col + CW'(1);
        w_row_n = w_row;
        if (w_col == C_LAST) begin
            w_col_n = '0;
            w_row_n = (w_row == R_LAST) ? '0 : w_row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            r_col <= w_col_n;
            r_row <= w_row_n;
        end
    end

    // r_left captures the old row r-1 value before it is overwritten, so it
    // serves as the left neighbour when the next column of row r arrives.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            r_lb0[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= in_pixel;
            r_left       <= r_lb1[w_col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quad_valid <= 1'b0;
            quad_last  <= 1'b0;
            frame_done <= 1'b0;
            quad       <= '0;
        end else begin
            quad_valid <= w_emit;
            quad_last  <= w_emit && w_last;
            frame_done <= w_done;
            if (w_emit)
                quad <= {r_lb0[w_col], in_pixel, r_left, r_lb1[w_cp1]};
        end
    end
endmodule

// File: tb/tb_pixel_quad_gen.sv
// Scoreboard bench: a frame-image model predicts each quad and frame_done pulse,
// checked against a 4x4 instance and a default-size instance.
module tb_pixel_quad_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic        in_sof = 1'b0;
    logic        qv_s, ql_s, fd_s, qv_b, ql_b, fd_b;
    logic [31:0] q_s, q_b;

    logic        sel = 1'b0;
    logic        qv, ql, fd;
    logic [31:0] q;
    assign qv = sel ? qv_b : qv_s;
    assign ql = sel ? ql_b : ql_s;
    assign fd = sel ? fd_b : fd_s;
    assign q  = sel ? q_b  : q_s;

    pixel_quad_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_sof(in_sof),
        .quad_valid(qv_s), .quad(q_s), .quad_last(ql_s), .frame_done(fd_s));
    pixel_quad_gen u_big (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_sof(in_sof),
        .quad_valid(qv_b), .quad(q_b), .quad_last(ql_b), .frame_done(fd_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic        l;
        int          c;
    } exp_t;

    exp_t        sbq[$];
    int          fdq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_q = 0;
    int          cyc = 0;
    logic        rst_q = 1'b1;
    logic [31:0] last_q = '0;
    int          W = 4, H = 4, mr = 0, mc = 0;
    logic [7:0]  img [0:119][0:159];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            last_q <= '0;
        end else begin
            if (qv) begin
                if (sbq.size() == 0) begin
                    chk("spurious_quad", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("quad", q, e.q);
                    chk("quad_last", ql, e.l);
                    chk("quad_cycle", cyc, e.c);
                end
                n_q    <= n_q + 1;
                last_q <= q;
            end else begin
                chk("quad_hold", q, last_q);
            end
            if (fd) begin
                if (fdq.size() == 0) chk("spurious_done", 1, 0);
                else chk("done_cycle", cyc, fdq.pop_front());
            end
        end
    end

    // Drive one cycle and update the reference image/position model.
    task automatic drive(input logic v, input logic [7:0] p, input logic s);
        exp_t e;
        @(posedge clk); #1;
        in_valid = v; in_pixel = p; in_sof = s;
        if (v) begin
            if (s) begin mr = 0; mc = 0; end
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 1 && mc <= W - 2) begin
                e.q = {img[mr-2][mc], p, img[mr-1][mc-1], img[mr-1][mc+1]};
                e.l = (mr == H - 1) && (mc == W - 2);
                e.c = cyc + 1;
                sbq.push_back(e);
            end
            if (mr == H - 1 && mc == W - 1) fdq.push_back(cyc + 1);
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom));
    endtask

    // Reset with in_valid/in_sof also high to exercise priority; switch DUT while in reset.
    task automatic do_reset(input logic nsel);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_pixel = 8'hA5;
        @(posedge clk); #1;
        sel = nsel;
        W = nsel ? 160 : 4;
        H = nsel ? 120 : 4;
        chk("rst_qv", qv, 0);
        chk("rst_ql", ql, 0);
        chk("rst_fd", fd, 0);
        chk("rst_quad", q, 0);
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        mr = 0; mc = 0;
        sbq.delete(); fdq.delete();
    endtask

    // gap: number of idle cycles after each pixel; npix < 0 means a full frame.
    task automatic small_frame(input int base, input int gap, input logic sof, input int npix);
        int n;
        n = (npix < 0) ? 16 : npix;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 8'(16 * (i / 4) + (i % 4) + base), (i == 0) ? sof : 1'b0);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic finish_test(input string tag, input int start, input int exp_n);
        idle(3);
        chk({tag, "_count"}, n_q - start, exp_n);
        chk({tag, "_sb_empty"}, sbq.size(), 0);
        chk({tag, "_done_empty"}, fdq.size(), 0);
    endtask

    initial begin
        int s;
        repeat (3) @(posedge clk);
        do_reset(1'b0);

        s = n_q; small_frame(0, 0, 1'b1, -1);
        finish_test("cont", s, 4);

        s = n_q; small_frame(0, 2, 1'b0, -1);
        finish_test("gaps", s, 4);

        s = n_q; small_frame(0, 0, 1'b1, -1); small_frame(100, 0, 1'b0, -1);
        finish_test("b2b", s, 8);

        s = n_q; small_frame(0, 0, 1'b1, 7); small_frame(0, 0, 1'b1, -1);
        finish_test("sof_abort", s, 4);

        s = n_q; small_frame(0, 0, 1'b1, 10);
        do_reset(1'b0);
        small_frame(0, 0, 1'b0, -1);
        finish_test("rst_mid", s, 5);

        do_reset(1'b1);
        s = n_q;
        for (int i = 0; i < 160 * 120; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        finish_test("random", s, 158 * 118);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_quad_gen.md
PIXEL_QUAD_GEN -- requirements
Module: pixel_quad_gen

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 160, pixels per row; legal range >= 3.
REQ-003 Parameter IMG_H, default 120, rows per frame; legal range >= 3.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  in_pixel carries the next raster-order pixel this cycle.
REQ-007 Port in_pixel  input  PIX_W  pixel data, row-major, column 0 first.
REQ-008 Port in_sof  input  1  qualified by in_valid; marks pixel (0,0) of a new frame.
REQ-009 Port quad_valid  output  1  quad is valid this cycle.
REQ-010 Port quad  output  4*PIX_W  {top, bottom, left, right}, with top in the MSBs: the 4-neighbours of one interior pixel, in the gradient-magnitude unit's input order.
REQ-011 Port quad_last  output  1  asserted with the final quad of a frame.
REQ-012 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 The block SHALL track the input column c (0..IMG_W-1) and row r (0..IMG_H-1), advancing only on cycles with in_valid=1.
- c wraps to 0 after IMG_W-1, incrementing r.
- r wraps to 0 after IMG_H-1.
REQ-014 The block SHALL accept in_valid gaps of any length with no loss of state; it has no backpressure.
REQ-015 The block SHALL retain the two most recent rows, plus the current partial row, in internal line storage.
REQ-016 A quad SHALL be produced for each interior centre (R,C), 1<=R<=IMG_H-2 and 1<=C<=IMG_W-2, when input pixel (R+1,C) is accepted.
REQ-017 For centre (R,C), quad SHALL be:
- top = P(R-1,C)
- bottom = P(R+1,C)
- left = P(R,C-1)
- right = P(R,C+1)
REQ-018 quad and quad_valid SHALL be registered, asserting exactly one cycle after the accepting cycle of P(R+1,C).
REQ-019 quad_valid SHALL be high for exactly one cycle per quad, producing (IMG_W-2)*(IMG_H-2) quads per frame.
REQ-020 No quad SHALL be produced for border centres, nor while r<2 or c=0 or c=IMG_W-1 on the accepting pixel.
REQ-021 quad SHALL hold its last value while quad_valid=0.
REQ-022 quad_last SHALL assert together with quad_valid for centre (IMG_H-2, IMG_W-2) only.
REQ-023 frame_done SHALL pulse for one cycle, one cycle after pixel (IMG_H-1, IMG_W-1) is accepted.
REQ-024 in_sof=1 with in_valid=1 SHALL force this pixel to be (0,0), discarding any partial frame.
- No quad is produced from pixels of the aborted frame after that cycle.
- A quad already registered in the output stage still presents normally in the following cycle.
REQ-025 in_sof at c=0, r=0 SHALL have no effect beyond normal behaviour; in_sof with in_valid=0 SHALL be ignored.
REQ-026 After the last pixel of a frame, the block SHALL accept the next frame immediately, with or without in_sof.
REQ-027 Line storage contents SHALL never be emitted in a quad unless written during the current frame.

Reset
REQ-028 While rst=1, the outputs SHALL be quad_valid=0, quad_last=0, frame_done=0 and quad=0; the row and column counters SHALL be 0.
REQ-029 rst SHALL take priority over in_valid and in_sof in the same cycle.
REQ-030 rst asserted mid-frame SHALL abandon the frame; the first pixel accepted after reset is (0,0).
REQ-031 Line storage SHALL not require reset.

Verification
REQ-032 IMG_W=4, IMG_H=4, P(r,c)=16r+c, continuous in_valid:
- exactly 4 quads are produced.
- first quad = {8'd1, 8'd33, 8'd16, 8'd18}, one cycle after pixel index 9.
- last quad = {8'd18, 8'd50, 8'd33, 8'd35} with quad_last=1, one cycle after pixel index 14.
- frame_done pulses one cycle after pixel index 15.
REQ-033 Same frame as REQ-032 with in_valid toggling 1,0,0,1,...: identical quad values and count; each quad lags its triggering pixel by exactly one cycle.
REQ-034 Two back-to-back frames, second with P=16r+c+100: 8 quads in total; second frame's first quad = {8'd101, 8'd133, 8'd116, 8'd118}.
REQ-035 in_sof asserted at pixel index 7 of a frame, followed by a full frame: only the 4 quads of the new frame appear after that cycle, with values as in REQ-032.
REQ-036 rst pulsed at pixel index 10, then a full frame: outputs are 0 during rst; the next 4 quads match REQ-032.
REQ-037 Default parameters, random pixel stream: 158*118 quads; every quad matches a reference-model neighbour lookup.
